// File: rtl/delay_line_pkg.sv
// delay_line_pkg: shared helpers and constants for the delay_line slice
package delay_line_pkg;

    localparam logic DEF_RVAL_BIT = 1'b0;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    // Tap select never collapses to zero bits, so DEPTH=1 still has a 1-bit tap port.
    function automatic int tap_width(input int depth);
        return (clog2(depth) > 1) ? clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/delay_stage.sv
// delay_stage: one data register plus its valid flop
//   clk, rst    : clock, synchronous active-high reset (loads RVAL, clears valid)
//   en          : advance strobe, loads d/d_vld when high
//   clr         : clears the valid flop only, data still advances
//   d, d_vld    : stage input
//   q, q_vld    : stage output
module delay_stage #(
    parameter int WIDTH = 8,
    parameter logic [WIDTH-1:0] RVAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] d,
    input  logic             d_vld,
    output logic [WIDTH-1:0] q,
    output logic             q_vld
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q     <= RVAL;
            q_vld <= 1'b0;
        end else begin
            if (en) q <= d;
            if (clr) q_vld <= 1'b0;
            else if (en) q_vld <= d_vld;
        end
    end

endmodule

// File: rtl/delay_line.sv
// delay_line: DEPTH-stage WIDTH-bit delay line with valid bits, runtime tap select and fill flag
//   clk, rst    : clock, synchronous active-high reset
//   en          : advance strobe
//   clr         : clears valid bits and fill count, data still shifts
//   i, i_vld    : data input and its valid qualifier
//   tap         : output tap, tap=k gives k+1 advances of delay, clamps to DEPTH-1
//   o, o_vld    : data and valid at the selected tap
//   primed      : DEPTH advances seen since the last rst/clr
//   byp         : only with DELAY_LINE_BYPASS_EN defined; routes i/i_vld straight to o/o_vld
module delay_line
    import delay_line_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter logic [WIDTH-1:0] RVAL = {WIDTH{DEF_RVAL_BIT}},
    localparam int TAPW = tap_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] i,
    input  logic             i_vld,
    input  logic [TAPW-1:0]  tap,
`ifdef DELAY_LINE_BYPASS_EN
    input  logic             byp,
`endif
    output logic [WIDTH-1:0] o,
    output logic             o_vld,
    output logic             primed
);

    localparam int CW = clog2(DEPTH + 1);
    localparam logic [TAPW-1:0] LAST = TAPW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [WIDTH-1:0] d [DEPTH];
    logic [WIDTH-1:0] q [DEPTH];
    logic [DEPTH-1:0] dv;
    logic [DEPTH-1:0] qv;
    logic [CW-1:0]    cnt;
    logic [TAPW-1:0]  t;

    genvar k;
    generate
        for (k = 0; k < DEPTH; k++) begin : g_stage
            if (k == 0) begin : g_head
                assign d[k]  = i;
                assign dv[k] = i_vld;
            end else begin : g_body
                assign d[k]  = q[k-1];
                assign dv[k] = qv[k-1];
            end
            delay_stage #(.WIDTH(WIDTH), .RVAL(RVAL)) u_stage (
                .clk   (clk),
                .rst   (rst),
                .en    (en),
                .clr   (clr),
                .d     (d[k]),
                .d_vld (dv[k]),
                .q     (q[k]),
                .q_vld (qv[k])
            );
        end
    endgenerate

    // Saturating fill counter; clr wins over a simultaneous advance.
    always_ff @(posedge clk) begin
        if (rst || clr) cnt <= '0;
        else if (en && cnt != FULL) cnt <= cnt + 1'b1;
    end

    always_comb begin
        t = (tap > LAST) ? LAST : tap;
    end

`ifdef DELAY_LINE_BYPASS_EN
    assign o     = byp ? i : q[t];
    assign o_vld = byp ? i_vld : qv[t];
`else
    assign o     = q[t];
    assign o_vld = qv[t];
`endif
    assign primed = cnt == FULL;

endmodule

// File: tb/tb_delay_line.sv
// tb_delay_line: scoreboard bench for delay_line (DEPTH=4 RVAL=A5 main instance, DEPTH=3 instance pinned at tap 3)
module tb_delay_line;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       clr = 1'b0;
    logic       i_vld = 1'b0;
    logic [7:0] i = 8'h00;
    logic [1:0] tap = 2'd0;
    logic [1:0] tap3 = 2'd3;
    logic [7:0] o, o3;
    logic       o_vld, o_vld3, primed, primed3;
`ifdef DELAY_LINE_BYPASS_EN
    logic       byp = 1'b0;
`endif

    int checks = 0;
    int failures = 0;
    logic [8:0] sb[$];
    logic [8:0] sb3[$];

    always #5 clk = ~clk;

    delay_line #(.WIDTH(8), .DEPTH(4), .RVAL(8'hA5)) dut (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .clr    (clr),
        .i      (i),
        .i_vld  (i_vld),
        .tap    (tap),
`ifdef DELAY_LINE_BYPASS_EN
        .byp    (byp),
`endif
        .o      (o),
        .o_vld  (o_vld),
        .primed (primed)
    );

    delay_line #(.WIDTH(8), .DEPTH(3)) dut3 (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .clr    (clr),
        .i      (i),
        .i_vld  (i_vld),
        .tap    (tap3),
`ifdef DELAY_LINE_BYPASS_EN
        .byp    (1'b0),
`endif
        .o      (o3),
        .o_vld  (o_vld3),
        .primed (primed3)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        en = 1'b0;
        clr = 1'b0;
        step();
        rst = 1'b0;
        sb.delete();
        sb3.delete();
    endtask

    task automatic shift_word(input logic [7:0] w, input logic v);
        i = w;
        i_vld = v;
        en = 1'b1;
        sb.push_back({v, w});
        sb3.push_back({v, w});
        step();
        en = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        en = 1'b1;
        clr = 1'b1;
        i = 8'hFF;
        i_vld = 1'b1;
        step();
        rst = 1'b0;
        en = 1'b0;
        clr = 1'b0;
        for (int t = 0; t < 4; t++) begin
            tap = 2'(t);
            #1;
            checks++;
            if ({o_vld, o} !== {1'b0, 8'hA5}) begin
                failures++;
                $display("FAIL reset tap%0d: got %b/%h want 0/a5", t, o_vld, o);
            end
            checks++;
            if (primed !== 1'b0) begin
                failures++;
                $display("FAIL reset primed tap%0d: got %b want 0", t, primed);
            end
        end
        checks++;
        if ({primed3, o_vld3, o3} !== {1'b0, 1'b0, 8'h00}) begin
            failures++;
            $display("FAIL reset depth3: got %b/%b/%h want 0/0/00", primed3, o_vld3, o3);
        end
    endtask

    task automatic test_latency();
        logic [8:0] e;
        do_reset();
        tap = 2'd2;
        for (int n = 1; n <= 8; n++) begin
            shift_word(8'(n), 1'b1);
            checks++;
            if (primed !== (n >= 4)) begin
                failures++;
                $display("FAIL latency primed adv%0d: got %b want %b", n, primed, n >= 4);
            end
            e = (sb.size() == 3) ? sb.pop_front() : {1'b0, 8'hA5};
            checks++;
            if ({o_vld, o} !== e) begin
                failures++;
                $display("FAIL latency tap2 adv%0d: got %b/%h want %b/%h", n, o_vld, o, e[8], e[7:0]);
            end
            e = (sb3.size() == 3) ? sb3.pop_front() : 9'h000;
            checks++;
            if ({o_vld3, o3} !== e) begin
                failures++;
                $display("FAIL clamp depth3 adv%0d: got %b/%h want %b/%h", n, o_vld3, o3, e[8], e[7:0]);
            end
        end
    endtask

    task automatic test_stall();
        logic [8:0] e, held, held3;
        do_reset();
        tap = 2'd3;
        for (int n = 1; n <= 12; n++) begin
            if (n >= 4 && n <= 8) begin
                held = {o_vld, o};
                held3 = {o_vld3, o3};
                en = 1'b0;
                i = 8'hEE;
                i_vld = 1'b1;
                step();
                checks++;
                if ({o_vld, o} !== held || {o_vld3, o3} !== held3) begin
                    failures++;
                    $display("FAIL stall cyc%0d: got %b/%h %b/%h want %b/%h %b/%h", n, o_vld, o, o_vld3, o3, held[8], held[7:0], held3[8], held3[7:0]);
                end
            end else begin
                shift_word(8'h10 + 8'(n), (n % 2) == 1);
                e = (sb.size() == 4) ? sb.pop_front() : {1'b0, 8'hA5};
                checks++;
                if ({o_vld, o} !== e) begin
                    failures++;
                    $display("FAIL stall tap3 n%0d: got %b/%h want %b/%h", n, o_vld, o, e[8], e[7:0]);
                end
                e = (sb3.size() == 3) ? sb3.pop_front() : 9'h000;
                checks++;
                if ({o_vld3, o3} !== e) begin
                    failures++;
                    $display("FAIL stall depth3 n%0d: got %b/%h want %b/%h", n, o_vld3, o3, e[8], e[7:0]);
                end
            end
        end
    endtask

    task automatic test_clear();
        tap = 2'd0;
        shift_word(8'h55, 1'b1);
        checks++;
        if ({primed, o_vld, o} !== {1'b1, 1'b1, 8'h55}) begin
            failures++;
            $display("FAIL clear pre: got %b/%b/%h want 1/1/55", primed, o_vld, o);
        end
        clr = 1'b1;
        shift_word(8'h77, 1'b1);
        clr = 1'b0;
        checks++;
        if ({primed, o_vld, o} !== {1'b0, 1'b0, 8'h77}) begin
            failures++;
            $display("FAIL clear tap0: got %b/%b/%h want 0/0/77", primed, o_vld, o);
        end
        tap = 2'd1;
        #1;
        checks++;
        if ({o_vld, o} !== {1'b0, 8'h55}) begin
            failures++;
            $display("FAIL clear tap1: got %b/%h want 0/55", o_vld, o);
        end
        tap = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            shift_word(8'h80 + 8'(k), 1'b1);
            checks++;
            if ({primed, o_vld, o} !== {k == 4, 1'b1, 8'h80 + 8'(k)}) begin
                failures++;
                $display("FAIL refill adv%0d: got %b/%b/%h want %b/1/%h", k, primed, o_vld, o, k == 4, 8'h80 + 8'(k));
            end
        end
        tap = 2'd3;
        #1;
        checks++;
        if ({o_vld, o} !== {1'b1, 8'h81}) begin
            failures++;
            $display("FAIL refill tap3: got %b/%h want 1/81", o_vld, o);
        end
    endtask

    task automatic test_precedence();
        rst = 1'b1;
        clr = 1'b1;
        en = 1'b1;
        i = 8'hFF;
        i_vld = 1'b1;
        step();
        rst = 1'b0;
        clr = 1'b0;
        en = 1'b0;
        for (int t = 0; t < 4; t += 3) begin
            tap = 2'(t);
            #1;
            checks++;
            if ({primed, o_vld, o} !== {1'b0, 1'b0, 8'hA5}) begin
                failures++;
                $display("FAIL precedence tap%0d: got %b/%b/%h want 0/0/a5", t, primed, o_vld, o);
            end
        end
        checks++;
        if ({primed3, o_vld3, o3} !== {1'b0, 1'b0, 8'h00}) begin
            failures++;
            $display("FAIL precedence depth3: got %b/%b/%h want 0/0/00", primed3, o_vld3, o3);
        end
    endtask

`ifdef DELAY_LINE_BYPASS_EN
    task automatic test_bypass();
        do_reset();
        tap = 2'd3;
        byp = 1'b1;
        en = 1'b1;
        i = 8'h3C;
        i_vld = 1'b1;
        #1;
        checks++;
        if ({o_vld, o} !== {1'b1, 8'h3C}) begin
            failures++;
            $display("FAIL bypass same cycle: got %b/%h want 1/3c", o_vld, o);
        end
        step();
        en = 1'b0;
        byp = 1'b0;
        tap = 2'd0;
        #1;
        checks++;
        if ({primed, o_vld, o} !== {1'b0, 1'b1, 8'h3C}) begin
            failures++;
            $display("FAIL bypass drop: got %b/%b/%h want 0/1/3c", primed, o_vld, o);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_latency();
        test_stall();
        test_clear();
        test_precedence();
`ifdef DELAY_LINE_BYPASS_EN
        test_bypass();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
